// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - MSB-first multi-cycle eq/gt/lt comparator, CHUNK bits per clock
// Define SEQ_CMP_EARLY_EXIT_EN to finish on the first differing chunk instead of constant-time.
module seq_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("seq_magnitude_comparator: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [IDXW-1:0]   idx;
    logic              gt_r;
    logic              lt_r;
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic              last_chunk;
    logic              accept;

    // Operands are shifted left each cycle so the chunk under test is always at the top.
    assign chunk_a    = a_sh[WIDTH-1 -: CHUNK];
    assign chunk_b    = b_sh[WIDTH-1 -: CHUNK];
    assign last_chunk = (idx == LAST_IDX);
    assign accept     = (state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
`ifdef SEQ_CMP_EARLY_EXIT_EN
                if (last_chunk || (chunk_a != chunk_b)) begin
                    state_next = DONE;
                end
`else
                if (last_chunk) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Signed operands get their MSB flipped so the chunk walk can stay purely unsigned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            idx  <= '0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
        end else begin
            if (accept) begin
                a_sh <= a ^ (signed_mode ? MSB_MASK : '0);
                b_sh <= b ^ (signed_mode ? MSB_MASK : '0);
                idx  <= '0;
                gt_r <= 1'b0;
                lt_r <= 1'b0;
            end else if (state == BUSY) begin
                a_sh <= a_sh << CHUNK;
                b_sh <= b_sh << CHUNK;
                if (!last_chunk) begin
                    idx <= idx + 1'b1;
                end
                if (!gt_r && !lt_r) begin
                    gt_r <= (chunk_a > chunk_b);
                    lt_r <= (chunk_a < chunk_b);
                end
            end else if (state == DONE && out_ready) begin
                gt_r <= 1'b0;
                lt_r <= 1'b0;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign gt        = out_valid & gt_r;
    assign lt        = out_valid & lt_r;
    assign eq        = out_valid & ~gt_r & ~lt_r;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - randomized self-checking bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;

    localparam int WIDTH  = 8;
    localparam int CHUNK  = 2;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             busy;

    int asserts = 0;
    int fails   = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .eq         (eq),
        .gt         (gt),
        .lt         (lt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result as {eq,gt,lt} from plain integer arithmetic.
    function automatic logic [2:0] ref_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
        int xi;
        int yi;
        xi = s ? $signed({{(32-WIDTH){x[WIDTH-1]}}, x}) : int'({{(32-WIDTH){1'b0}}, x});
        yi = s ? $signed({{(32-WIDTH){y[WIDTH-1]}}, y}) : int'({{(32-WIDTH){1'b0}}, y});
        if (xi == yi) return 3'b100;
        return (xi > yi) ? 3'b010 : 3'b001;
    endfunction

    // Cycles from accept to out_valid; the MSB flip in signed mode never changes which bits differ.
    function automatic int ref_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
`ifdef SEQ_CMP_EARLY_EXIT_EN
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int j = 0; j < NCHUNK; j++) begin
            if (((d >> (WIDTH - (j + 1) * CHUNK)) & ((1 << CHUNK) - 1)) != 0) return j + 1;
        end
`endif
        return NCHUNK;
    endfunction

    // Transaction-level model: idle, counting down a latency, or holding a result.
    bit       m_idle = 1'b1;
    int       m_rem  = 0;
    bit       m_done = 1'b0;
    logic [2:0] m_res = 3'b000;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1;
            m_rem  = 0;
            m_done = 1'b0;
            m_res  = 3'b000;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle = 1'b0;
                m_rem  = ref_lat(a, b);
                m_res  = ref_cmp(a, b, signed_mode);
            end
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (m_done && out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            check("cycle_outputs", {26'd0, in_ready, busy, out_valid, eq, gt, lt},
                  {26'd0, m_idle, (m_rem > 0), m_done, (m_done ? m_res : 3'b000)});
        end
    end

    // Starts and ends on a negedge in IDLE; toggles a/b/in_valid while the op is in flight.
    task automatic run_op(input string name, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic s, input logic [2:0] exp_res, input int exp_lat, input int hold);
        int lat;
        logic [2:0] held;
        a = xa;
        b = xb;
        signed_mode = s;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 64) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            signed_mode = 1'($urandom);
            in_valid = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, {29'd0, eq, gt, lt}, {29'd0, exp_res});
        held = {eq, gt, lt};
        for (int h = 0; h < hold; h++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(negedge clk);
            check({name, "_hold"}, {28'd0, out_valid, eq, gt, lt}, {28'd0, 1'b1, held});
            check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle_after"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
    endtask

`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam int LAT_80_7F = 1;
    localparam int LAT_34_21 = 2;
`else
    localparam int LAT_80_7F = 4;
    localparam int LAT_34_21 = 4;
`endif

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {26'd0, in_ready, busy, out_valid, eq, gt, lt}, 32'b100000);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        check("model_signed_min", {29'd0, ref_cmp(8'h80, 8'h7F, 1'b1)}, 32'b001);
        check("model_unsigned_msb", {29'd0, ref_cmp(8'h80, 8'h7F, 1'b0)}, 32'b010);

        run_op("eq_5a", 8'h5A, 8'h5A, 1'b0, 3'b100, 4, 0);
        run_op("u_80_7f", 8'h80, 8'h7F, 1'b0, 3'b010, LAT_80_7F, 0);
        run_op("s_80_7f", 8'h80, 8'h7F, 1'b1, 3'b001, LAT_80_7F, 1);
        run_op("s_ff_fe", 8'hFF, 8'hFE, 1'b1, 3'b010, 4, 0);
        run_op("u_12_13", 8'h12, 8'h13, 1'b0, 3'b001, 4, 0);
        run_op("backpressure", 8'h34, 8'h21, 1'b0, 3'b010, LAT_34_21, 3);

        // Reset in the second BUSY cycle discards the in-flight compare.
        a = 8'h00;
        b = 8'hFF;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy_reset", {29'd0, in_ready, out_valid, busy}, 32'b100);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_reset", 8'h01, 8'h02, 1'b0, 3'b001, 4, 0);

        for (int n = 0; n < 60; n++) begin
            ra = WIDTH'($urandom);
            rs = 1'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = WIDTH'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            endcase
            run_op("random", ra, rb, rs, ref_cmp(ra, rb, rs), ref_lat(ra, rb), $urandom_range(0, 2));
        end

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
